// File: rtl/soc_sysid_ext_if.sv
// soc_sysid_ext_if -- Avalon-MM slave bus bundle for the system-ID block.
//
// Parameter:
//   ADDR_W        word-address width
// Signals:
//   address       word address          (master -> slave)
//   read, write   single-cycle strobes   (master -> slave)
//   writedata     32-bit write data      (master -> slave)
//   readdata      32-bit registered data (slave -> master)
//   readdatavalid read response strobe   (slave -> master)
`timescale 1ns/1ps

interface soc_sysid_ext_if #(
  parameter int ADDR_W = 5
) ();
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/soc_sysid_ext.sv
// soc_sysid_ext -- system identification register block with an optional
// 64-bit uptime counter, behind an Avalon-MM slave with fixed 1-cycle read
// latency (no waitrequest).
//
// Word map:
//   0 ID (RO)   1 TIMESTAMP (RO)   2 CAPS (RO)   3 SCRATCH (RW)
//   4 UPTIME_LO (RO)  5 UPTIME_HI (RO, shadow)  6 CTRL (WO, reads 0)
//   7 reserved        8..8+NUM_USER-1 USER[k] (RO)
//
// Optional feature: define SOC_SYSID_UPTIME_EN to build the uptime counter,
// its HI shadow and the CTRL clear. Without it, offsets 4..6 read 0 and CTRL
// writes do nothing.
//
// Ports:
//   clock       sole clock, rising edge
//   reset       asynchronous active-high reset
//   user_words  NUM_USER flat 32-bit user ID words, word k at [32k+31:32k];
//               quasi-static, sampled in the read-strobe cycle
//   bus         soc_sysid_ext_if slave modport (Avalon-MM)
`timescale 1ns/1ps

module soc_sysid_ext #(
  parameter logic [31:0] ID_VALUE  = 32'h0100_0001,
  parameter logic [31:0] TIMESTAMP = 32'd1479824168,
  parameter int          NUM_USER  = 4,
  parameter int          ADDR_W    = 5
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [32*NUM_USER-1:0]  user_words,
  soc_sysid_ext_if.slave          bus
);

  if (NUM_USER < 1 || NUM_USER > 16) begin : g_bad_num_user
    $error("soc_sysid_ext: NUM_USER must be in 1..16");
  end
  if ((2 ** ADDR_W) < (8 + NUM_USER)) begin : g_bad_addr_w
    $error("soc_sysid_ext: ADDR_W too small for the register map");
  end

  localparam logic [ADDR_W-1:0] OFS_ID      = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] OFS_TSTAMP  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] OFS_CAPS    = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] OFS_SCRATCH = ADDR_W'(3);
`ifdef SOC_SYSID_UPTIME_EN
  localparam logic [ADDR_W-1:0] OFS_UP_LO   = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] OFS_UP_HI   = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] OFS_CTRL    = ADDR_W'(6);
  localparam logic              HAS_UPTIME  = 1'b1;
`else
  localparam logic              HAS_UPTIME  = 1'b0;
`endif
  localparam int                OFS_USER0   = 8;

  localparam logic [3:0]  CAPS_AW = 4'(ADDR_W);
  localparam logic [4:0]  CAPS_NU = 5'(NUM_USER);
  localparam logic [31:0] CAPS_VALUE =
    {16'h0, CAPS_AW, 3'b000, HAS_UPTIME, 3'b000, CAPS_NU};

  // A simultaneous read wins; the write is dropped entirely.
  logic wr_en;
  assign wr_en = bus.write & ~bus.read;

  logic [31:0] scratch_q;
  logic [31:0] rd_mux;

`ifdef SOC_SYSID_UPTIME_EN
  logic [63:0] uptime_q;
  logic [31:0] shadow_q;
  logic        clear;

  assign clear = wr_en && (bus.address == OFS_CTRL) && bus.writedata[0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      uptime_q <= '0;
      shadow_q <= '0;
    end else begin
      // Wraps naturally at 2**64-1.
      uptime_q <= clear ? 64'd0 : uptime_q + 64'd1;
      // Latch the upper half in the same cycle as the LO read so a later HI
      // read is coherent even if a carry ripples in between.
      if (bus.read && (bus.address == OFS_UP_LO))
        shadow_q <= uptime_q[63:32];
    end
  end
`endif

  // Read multiplexer; reserved, unmapped and write-only offsets return 0.
  always_comb begin
    // NOTE: default assignment first so every path drives rd_mux and no latch
    // is inferred.
    rd_mux = '0;
    case (bus.address)
      OFS_ID:      rd_mux = ID_VALUE;
      OFS_TSTAMP:  rd_mux = TIMESTAMP;
      OFS_CAPS:    rd_mux = CAPS_VALUE;
      OFS_SCRATCH: rd_mux = scratch_q;
`ifdef SOC_SYSID_UPTIME_EN
      OFS_UP_LO:   rd_mux = uptime_q[31:0];
      OFS_UP_HI:   rd_mux = shadow_q;
`endif
      default:     rd_mux = '0;
    endcase
    for (int k = 0; k < NUM_USER; k++) begin
      if (bus.address == ADDR_W'(OFS_USER0 + k))
        rd_mux = user_words[32*k +: 32];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: non-blocking assignments for all clocked state so every register
      // samples pre-edge values regardless of statement order.
      scratch_q         <= '0;
      bus.readdata      <= '0;
      bus.readdatavalid <= 1'b0;
    end else begin
      bus.readdatavalid <= bus.read;
      // readdata holds its last value between responses.
      if (bus.read)
        bus.readdata <= rd_mux;
      if (wr_en && (bus.address == OFS_SCRATCH))
        scratch_q <= bus.writedata;
    end
  end

endmodule
